// File: rtl/multicycle_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_pkg
// Purpose  : Shared types and encodings for the multicycle RISC-V controller:
//            FSM state enum, opcodes, ALUOp / ALUControl codes, datapath mux
//            selects, the per-state control bundle and its decode helpers.
// Ports    : n/a (package)
// Revision : 1.0 - initial release
// ============================================================================
package multicycle_pkg;

  // FSM states; the numeric value is exported on state_o for debug.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_e;

  // Opcodes (instr[6:0])
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  // ALUOp: what the ALU decoder should produce
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

  // ALUControl encodings
  localparam logic [2:0] ALUCTL_ADD = 3'b000;
  localparam logic [2:0] ALUCTL_SUB = 3'b001;
  localparam logic [2:0] ALUCTL_AND = 3'b010;
  localparam logic [2:0] ALUCTL_OR  = 3'b011;
  localparam logic [2:0] ALUCTL_SLT = 3'b101;

  // ALU source A select
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  // ALU source B select
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Result select
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // Immediate format select
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Moore control bundle, registered as a unit.
  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    alu_op_e    alu_op;
    logic       illegal;
  } ctrl_t;

  function automatic logic [1:0] imm_src_decode(input logic [6:0] opcode);
    logic [1:0] imm;
    case (opcode)
      OP_SW:   imm = IMM_S;
      OP_BEQ:  imm = IMM_B;
      OP_JAL:  imm = IMM_J;
      default: imm = IMM_I;
    endcase
    return imm;
  endfunction

  // Control values for a state. 'last' marks the final cycle of a wait,
  // which is the only FETCH cycle allowed to load IR and advance PC.
  function automatic ctrl_t state_ctrl(input state_e s, input logic last);
    ctrl_t c;
    c        = '0;
    c.alu_op = ALUOP_ADD;
    case (s)
      S_FETCH: begin
        c.alu_src_a  = SRCA_PC;
        c.alu_src_b  = SRCB_FOUR;
        c.result_src = RES_ALURESULT;
        c.ir_write   = last;
        c.pc_write   = last;
      end
      S_DECODE: begin
        c.alu_src_a = SRCA_OLDPC;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        c.adr_src    = 1'b1;
        c.result_src = RES_ALUOUT;
      end
      S_MEMWB: begin
        c.result_src = RES_DATA;
        c.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        c.adr_src    = 1'b1;
        c.result_src = RES_ALUOUT;
        c.mem_write  = 1'b1;
      end
      S_EXECR: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_RS2;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        c.result_src = RES_ALUOUT;
        c.reg_write  = 1'b1;
      end
      S_BEQ: begin
        // PCWrite here comes from the zero flag outside the register.
        c.alu_src_a  = SRCA_RS1;
        c.alu_src_b  = SRCB_RS2;
        c.alu_op     = ALUOP_SUB;
        c.result_src = RES_ALUOUT;
      end
      S_JAL: begin
        c.alu_src_a  = SRCA_OLDPC;
        c.alu_src_b  = SRCB_FOUR;
        c.result_src = RES_ALUOUT;
        c.pc_write   = 1'b1;
      end
      S_TRAP: begin
        c.illegal = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_control_if.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_if
// Purpose  : Bundle between datapath and multicycle controller.
// Ports    : master - datapath side: drives instruction fields and zero flag,
//                     receives all control outputs.
//            slave  - controller side: the mirror image.
// Revision : 1.0 - initial release
// ============================================================================
interface multicycle_control_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;

  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic [2:0] ALUControl;
  logic       illegal;
  logic [3:0] state_o;

  modport master (
    output opcode, funct3, funct7b5, zero,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal, state_o
  );

  modport slave (
    input  opcode, funct3, funct7b5, zero,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal, state_o
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_control_alu_decoder.sv
`default_nettype none
// ============================================================================
// Module   : alu_decoder
// Purpose  : Combinational ALUControl decode.
// Ports    : alu_op      - requested operation class
//            funct3      - instr[14:12]
//            funct7b5    - instr[30]
//            op5         - opcode[5]; set for R-type, so funct7b5 selects sub
//            alu_control - ALU operation code
// Revision : 1.0 - initial release
// ============================================================================
module alu_decoder
  import multicycle_pkg::*;
(
  input  alu_op_e    alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALUCTL_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALUCTL_ADD;
      ALUOP_SUB: alu_control = ALUCTL_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // I-type has no sub, so funct7b5 only matters for R-type.
          3'b000:  alu_control = (op5 & funct7b5) ? ALUCTL_SUB : ALUCTL_ADD;
          3'b010:  alu_control = ALUCTL_SLT;
          3'b110:  alu_control = ALUCTL_OR;
          3'b111:  alu_control = ALUCTL_AND;
          default: alu_control = ALUCTL_ADD;
        endcase
      end
      default: alu_control = ALUCTL_ADD;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Purpose  : Moore FSM controller for a multicycle RISC-V datapath
//            (lw, sw, R-type, I-type ALU, beq, jal; anything else traps).
//            Memory states (FETCH, MEMREAD, MEMWRITE) last MEM_LATENCY cycles.
// Ports    : clk - clock, rising edge
//            rst - synchronous reset, active low
//            bus - slave side of multicycle_control_if
// Params   : MEM_LATENCY - cycles per memory-access state, 1..15
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  multicycle_control_if.slave  bus
);

  localparam logic [3:0] CNT_RELOAD = 4'(MEM_LATENCY - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  ctrl_t      ctrl_q, ctrl_d;
  logic [2:0] alu_control;

  // Next state, wait counter, and the control bundle of the next state so
  // the outputs come straight from flops.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (cnt_q == 4'd0) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECR;
          OP_ITYPE:     state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_TRAP;
        endcase
      end
      // opcode[5] separates sw from lw
      S_MEMADR:   state_d = bus.opcode[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (cnt_q == 4'd0) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (cnt_q == 4'd0) state_d = S_FETCH;
      S_EXECR,
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_TRAP:     state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase

    // Every state change reloads; only the memory states ever stay put,
    // so the counter only runs down inside a wait.
    if (state_d != state_q) begin
      cnt_d = CNT_RELOAD;
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end else begin
      cnt_d = cnt_q;
    end

    ctrl_d = state_ctrl(state_d, cnt_d == 4'd0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_FETCH;
      cnt_q   <= CNT_RELOAD;
      ctrl_q  <= state_ctrl(S_FETCH, CNT_RELOAD == 4'd0);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
    end
  end

  alu_decoder u_alu_decoder (
    .alu_op      (ctrl_q.alu_op),
    .funct3      (bus.funct3),
    .funct7b5    (bus.funct7b5),
    .op5         (bus.opcode[5]),
    .alu_control (alu_control)
  );

  // Write enables are held off while reset is asserted; with MEM_LATENCY=1
  // the FETCH loaded by reset is already its last cycle.
  assign bus.PCWrite    = rst & (ctrl_q.pc_write | ((state_q == S_BEQ) & bus.zero));
  assign bus.MemWrite   = rst & ctrl_q.mem_write;
  assign bus.IRWrite    = rst & ctrl_q.ir_write;
  assign bus.RegWrite   = rst & ctrl_q.reg_write;
  assign bus.AdrSrc     = ctrl_q.adr_src;
  assign bus.ResultSrc  = ctrl_q.result_src;
  assign bus.ALUSrcA    = ctrl_q.alu_src_a;
  assign bus.ALUSrcB    = ctrl_q.alu_src_b;
  assign bus.ImmSrc     = imm_src_decode(bus.opcode);
  assign bus.ALUControl = alu_control;
  assign bus.illegal    = ctrl_q.illegal;
  assign bus.state_o    = state_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control
// Purpose  : Directed self-checking bench for multicycle_control with
//            MEM_LATENCY=1 (dut1) and MEM_LATENCY=3 (dut3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

  logic clk = 1'b0;
  logic rst1;
  logic rst3;
  int   n_checks = 0;
  int   n_fails  = 0;

  multicycle_control_if bus1 ();
  multicycle_control_if bus3 ();

  multicycle_control #(.MEM_LATENCY(1)) dut1 (.clk(clk), .rst(rst1), .bus(bus1));
  multicycle_control #(.MEM_LATENCY(3)) dut3 (.clk(clk), .rst(rst3), .bus(bus3));

  always #5 clk = ~clk;

  // {state, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
  //  ALUSrcA, ALUSrcB, ALUControl, illegal}
  function automatic logic [18:0] mk(input logic [3:0] st,
                                     input logic pcw, adr, memw, irw, regw,
                                     input logic [1:0] res, a, b,
                                     input logic [2:0] alu, input logic ill);
    return {st, pcw, adr, memw, irw, regw, res, a, b, alu, ill};
  endfunction

  function automatic logic [18:0] snap1();
    return {bus1.state_o, bus1.PCWrite, bus1.AdrSrc, bus1.MemWrite, bus1.IRWrite,
            bus1.RegWrite, bus1.ResultSrc, bus1.ALUSrcA, bus1.ALUSrcB,
            bus1.ALUControl, bus1.illegal};
  endfunction

  function automatic logic [18:0] snap3();
    return {bus3.state_o, bus3.PCWrite, bus3.AdrSrc, bus3.MemWrite, bus3.IRWrite,
            bus3.RegWrite, bus3.ResultSrc, bus3.ALUSrcA, bus3.ALUSrcB,
            bus3.ALUControl, bus3.illegal};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Common expected vectors
  logic [18:0] v_fetch_last, v_fetch_wait, v_fetch_rst, v_decode, v_aluwb;
  initial begin
    v_fetch_last = mk(4'd0, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0);
    v_fetch_wait = mk(4'd0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0);
    v_fetch_rst  = v_fetch_wait;
    v_decode     = mk(4'd1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 0);
    v_aluwb      = mk(4'd8, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 0);
  end

  task automatic test_reset();
    logic [18:0] obs;
    rst1 = 1'b0; rst3 = 1'b0;
    bus1.opcode = 7'b0110011; bus1.funct3 = 3'b000; bus1.funct7b5 = 1'b0; bus1.zero = 1'b0;
    bus3.opcode = 7'b0000011; bus3.funct3 = 3'b010; bus3.funct7b5 = 1'b0; bus3.zero = 1'b0;
    step(); step();
    obs = snap1(); n_checks++;
    if (obs !== v_fetch_rst) begin n_fails++; $display("FAIL reset_hold_l1 got %h want %h", obs, v_fetch_rst); end
    obs = snap3(); n_checks++;
    if (obs !== v_fetch_rst) begin n_fails++; $display("FAIL reset_hold_l3 got %h want %h", obs, v_fetch_rst); end
    rst1 = 1'b1;
    #1;
    obs = snap1(); n_checks++;
    if (obs !== v_fetch_last) begin n_fails++; $display("FAIL reset_release_l1 got %h want %h", obs, v_fetch_last); end
  endtask

  task automatic test_exec(input string name, input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input logic [3:0] st, input logic [1:0] srcb,
                           input logic [2:0] alu);
    logic [18:0] exp [5];
    logic [18:0] obs;
    bus1.opcode = op; bus1.funct3 = f3; bus1.funct7b5 = f7; bus1.zero = 1'b0;
    exp[0] = v_fetch_last;
    exp[1] = v_decode;
    exp[2] = mk(st, 0, 0, 0, 0, 0, 2'b00, 2'b10, srcb, alu, 0);
    exp[3] = v_aluwb;
    exp[4] = v_fetch_last;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      obs = snap1(); n_checks++;
      if (obs !== exp[i]) begin n_fails++; $display("FAIL %s cycle %0d got %h want %h", name, i, obs, exp[i]); end
      if (i == 1) begin
        n_checks++;
        if (bus1.ImmSrc !== 2'b00) begin n_fails++; $display("FAIL %s immsrc got %b want 00", name, bus1.ImmSrc); end
      end
    end
  endtask

  task automatic test_branch(input logic z);
    logic [18:0] exp [4];
    logic [18:0] obs;
    bus1.opcode = 7'b1100011; bus1.funct3 = 3'b000; bus1.funct7b5 = 1'b0; bus1.zero = z;
    exp[0] = v_fetch_last;
    exp[1] = v_decode;
    exp[2] = mk(4'd9, z, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 0);
    exp[3] = v_fetch_last;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      obs = snap1(); n_checks++;
      if (obs !== exp[i]) begin n_fails++; $display("FAIL beq_zero%0d cycle %0d got %h want %h", z, i, obs, exp[i]); end
      if (i == 1) begin
        n_checks++;
        if (bus1.ImmSrc !== 2'b10) begin n_fails++; $display("FAIL beq_immsrc got %b want 10", bus1.ImmSrc); end
      end
    end
  endtask

  task automatic test_jal();
    logic [18:0] exp [5];
    logic [18:0] obs;
    bus1.opcode = 7'b1101111; bus1.funct3 = 3'b111; bus1.funct7b5 = 1'b1; bus1.zero = 1'b0;
    exp[0] = v_fetch_last;
    exp[1] = v_decode;
    exp[2] = mk(4'd10, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 0);
    exp[3] = v_aluwb;
    exp[4] = v_fetch_last;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      obs = snap1(); n_checks++;
      if (obs !== exp[i]) begin n_fails++; $display("FAIL jal cycle %0d got %h want %h", i, obs, exp[i]); end
      if (i == 1) begin
        n_checks++;
        if (bus1.ImmSrc !== 2'b11) begin n_fails++; $display("FAIL jal_immsrc got %b want 11", bus1.ImmSrc); end
      end
    end
  endtask

  task automatic test_trap();
    logic [18:0] exp [4];
    logic [18:0] obs;
    bus1.opcode = 7'b1111111; bus1.funct3 = 3'b000; bus1.funct7b5 = 1'b0; bus1.zero = 1'b1;
    exp[0] = v_fetch_last;
    exp[1] = v_decode;
    exp[2] = mk(4'd11, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1);
    exp[3] = v_fetch_last;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      obs = snap1(); n_checks++;
      if (obs !== exp[i]) begin n_fails++; $display("FAIL trap cycle %0d got %h want %h", i, obs, exp[i]); end
    end
  endtask

  // dut3 held in reset until here; released at the start.
  task automatic test_lw_latency();
    logic [18:0] exp [10];
    logic [18:0] obs;
    bus3.opcode = 7'b0000011; bus3.funct3 = 3'b010; bus3.funct7b5 = 1'b0; bus3.zero = 1'b0;
    rst3 = 1'b1;
    exp[0] = v_fetch_wait;
    exp[1] = v_fetch_wait;
    exp[2] = v_fetch_last;
    exp[3] = v_decode;
    exp[4] = mk(4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0);
    exp[5] = mk(4'd3, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0);
    exp[6] = exp[5];
    exp[7] = exp[5];
    exp[8] = mk(4'd4, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 0);
    exp[9] = v_fetch_wait;
    #1;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) step();
      obs = snap3(); n_checks++;
      if (obs !== exp[i]) begin n_fails++; $display("FAIL lw_l3 cycle %0d got %h want %h", i, obs, exp[i]); end
      // opcode outside the sampling states must not disturb the wait
      if (i == 5) bus3.opcode = 7'b1111111;
    end
  endtask

  task automatic test_sw();
    logic [18:0] exp [9];
    logic [18:0] obs;
    bus3.opcode = 7'b0100011; bus3.funct3 = 3'b010; bus3.funct7b5 = 1'b0;
    exp[0] = v_fetch_wait;
    exp[1] = v_fetch_wait;
    exp[2] = v_fetch_last;
    exp[3] = v_decode;
    exp[4] = mk(4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0);
    exp[5] = mk(4'd5, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0);
    exp[6] = exp[5];
    exp[7] = exp[5];
    exp[8] = v_fetch_wait;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) step();
      obs = snap3(); n_checks++;
      if (obs !== exp[i]) begin n_fails++; $display("FAIL sw_l3 cycle %0d got %h want %h", i, obs, exp[i]); end
      if (i == 3) begin
        n_checks++;
        if (bus3.ImmSrc !== 2'b01) begin n_fails++; $display("FAIL sw_immsrc got %b want 01", bus3.ImmSrc); end
      end
    end
  endtask

  task automatic test_reset_mid_write();
    logic [18:0] exp [7];
    logic [18:0] obs;
    bus3.opcode = 7'b0100011; bus3.funct3 = 3'b010; bus3.funct7b5 = 1'b0;
    exp[0] = v_fetch_wait;
    exp[1] = v_fetch_wait;
    exp[2] = v_fetch_last;
    exp[3] = v_decode;
    exp[4] = mk(4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0);
    exp[5] = mk(4'd5, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0);
    exp[6] = exp[5];
    for (int i = 0; i < 7; i++) begin
      if (i > 0) step();
      obs = snap3(); n_checks++;
      if (obs !== exp[i]) begin n_fails++; $display("FAIL rstmid cycle %0d got %h want %h", i, obs, exp[i]); end
    end
    // now in MEMWRITE cycle 2 of 3
    rst3 = 1'b0;
    step();
    obs = snap3(); n_checks++;
    if (obs !== v_fetch_rst) begin n_fails++; $display("FAIL rstmid_inreset got %h want %h", obs, v_fetch_rst); end
    rst3 = 1'b1;
    #1;
    obs = snap3(); n_checks++;
    if (obs !== v_fetch_wait) begin n_fails++; $display("FAIL rstmid_after0 got %h want %h", obs, v_fetch_wait); end
    step();
    obs = snap3(); n_checks++;
    if (obs !== v_fetch_wait) begin n_fails++; $display("FAIL rstmid_after1 got %h want %h", obs, v_fetch_wait); end
    step();
    obs = snap3(); n_checks++;
    if (obs !== v_fetch_last) begin n_fails++; $display("FAIL rstmid_after2 got %h want %h", obs, v_fetch_last); end
  endtask

  initial begin
    #1;
    test_reset();
    test_exec("exec_sub",    7'b0110011, 3'b000, 1'b1, 4'd6, 2'b00, 3'b001);
    test_exec("exec_add_r",  7'b0110011, 3'b000, 1'b0, 4'd6, 2'b00, 3'b000);
    test_exec("exec_addi",   7'b0010011, 3'b000, 1'b1, 4'd7, 2'b01, 3'b000);
    test_exec("exec_slt",    7'b0110011, 3'b010, 1'b0, 4'd6, 2'b00, 3'b101);
    test_exec("exec_ori",    7'b0010011, 3'b110, 1'b0, 4'd7, 2'b01, 3'b011);
    test_exec("exec_and",    7'b0110011, 3'b111, 1'b0, 4'd6, 2'b00, 3'b010);
    test_exec("exec_other",  7'b0110011, 3'b001, 1'b1, 4'd6, 2'b00, 3'b000);
    test_branch(1'b1);
    test_branch(1'b0);
    test_jal();
    test_trap();
    test_lw_latency();
    test_sw();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 1, giving the cycles each memory-access state holds (range 1..15).
REQ-002 SHALL have port clk, input, 1, clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, synchronous, active-low.
REQ-004 SHALL have inputs: opcode 7 (instr[6:0]), funct3 3 (instr[14:12]), funct7b5 1 (instr[30]), zero 1 (ALU zero flag).
REQ-005 SHALL have outputs: PCWrite 1, AdrSrc 1, MemWrite 1, IRWrite 1, RegWrite 1 (drives register-file write enable).
REQ-006 SHALL have outputs: ResultSrc 2, ALUSrcA 2, ALUSrcB 2, ImmSrc 2, ALUControl 3, illegal 1, state_o 4 (debug copy of current state).

Function
REQ-007 SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, TRAP.
REQ-008 FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp add, ResultSrc=10; hold MEM_LATENCY cycles via down-counter; IRWrite=1 and PCWrite=1 only in last cycle; then DECODE.
REQ-009 DECODE (1 cycle): ALUSrcA=01, ALUSrcB=01, add (branch target); next by opcode: 0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1100011->BEQ, 1101111->JAL, other->TRAP.
REQ-010 MEMADR: ALUSrcA=10, ALUSrcB=01, add; lw->MEMREAD, sw->MEMWRITE.
REQ-011 MEMREAD: AdrSrc=1, ResultSrc=00, held MEM_LATENCY cycles, then MEMWB; MEMWB: ResultSrc=01, RegWrite=1, ->FETCH.
REQ-012 MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 every cycle, held MEM_LATENCY cycles, ->FETCH.
REQ-013 EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp funct; EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp funct; both ->ALUWB.
REQ-014 ALUWB: ResultSrc=00, RegWrite=1, ->FETCH.
REQ-015 BEQ: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00; PCWrite=zero (only combinational output); ->FETCH.
REQ-016 JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1; ->ALUWB (writes PC+4 to rd).
REQ-017 TRAP: illegal=1 for exactly one cycle, all write enables 0, ->FETCH.
REQ-018 ImmSrc SHALL decode from opcode in every state: I-type/lw 00, sw 01, beq 10, jal 11, others 00.
REQ-019 ALUControl: ALUOp add->000, sub->001; funct: funct3 000 -> 001 if (opcode==0110011 && funct7b5) else 000; 010->101; 110->011; 111->010; other->000.
REQ-020 All unlisted outputs SHALL be 0 in each state; MemWrite, RegWrite, IRWrite SHALL never be 1 simultaneously.
REQ-021 Wait counter SHALL reload to MEM_LATENCY-1 on entry to each memory state; MEM_LATENCY=1 gives single-cycle states.
REQ-022 Opcode and funct inputs SHALL be sampled only in DECODE/MEMADR/EXEC*; changes in other states SHALL be ignored.

Reset
REQ-023 rst=0 at a rising edge SHALL force state FETCH, counter to MEM_LATENCY-1, illegal=0, from any state, including mid-wait.
REQ-024 During and first cycle after reset all write enables (PCWrite, MemWrite, IRWrite, RegWrite) SHALL be 0 until FETCH counter expires.

Structure
REQ-025 Package multicycle_pkg SHALL hold the state enum (4-bit), opcode constants, ALUOp and ALUControl encodings, mux-select constants.
REQ-026 ALU-control decode SHALL be sub-module alu_decoder (combinational: ALUOp, funct3, funct7b5, opcode[5] -> ALUControl).

Verification
REQ-027 MEM_LATENCY=1, opcode 0110011, funct3 000, funct7b5=1 -> states FETCH,DECODE,EXECR,ALUWB; ALUControl=001 in EXECR; RegWrite=1 only in ALUWB.
REQ-028 lw (0000011) with MEM_LATENCY=3 -> FETCH 3 cycles (IRWrite on 3rd), MEMREAD 3 cycles, MEMWB RegWrite=1; total 9 cycles.
REQ-029 beq with zero=1 -> PCWrite=1 in BEQ; repeat with zero=0 -> PCWrite=0, RegWrite never 1.
REQ-030 opcode 1111111 -> DECODE->TRAP, illegal=1 one cycle, no write enable asserted, next state FETCH.
REQ-031 rst=0 asserted in MEMWRITE cycle 2 of 3 -> next state FETCH, MemWrite=0 following cycle, illegal=0.
